rocket_motion: RTL

Game-state and motion engine for the rocket game. Once per frame it moves the player ship from push-buttons, moves the bouncing planet, detects ship/planet collision, and manages lives. It sits directly upstream of the VGA sync/render stage. It drives that stage's x/y ship and planet coordinates and consumes its h_reverse/v_reverse bounce flags.

---
 rtl/rocket_motion.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/rocket_motion.sv
`default_nettype none
// ============================================================================
//  Module   : rocket_motion
//  Purpose  : Per-frame game engine for the rocket game. It moves the player
//             ship from the push-buttons and moves the bouncing planet. It
//             detects ship/planet collisions and tracks the remaining lives.
//             Its coordinates feed the VGA render stage, and that stage
//             returns the bounce direction flags.
//  Revision : 1.0  initial release
// ============================================================================
module rocket_motion #(
  parameter int FRAME_DIV   = 833333,
  parameter int SHIP_STEP   = 2,
  parameter int PLANET_STEP = 1,
  parameter int HIT_FRAMES  = 60,
  parameter int LIVES_INIT  = 3,
  parameter int X_MAX       = 624,
  parameter int Y_MAX       = 464,
  parameter int SHIP_X0     = 312,
  parameter int SHIP_Y0     = 400,
  parameter int PLANET_X0   = 0,
  parameter int PLANET_Y0   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        h_reverse,
  input  logic        v_reverse,
  output logic [15:0] x_ship,
  output logic [15:0] y_ship,
  output logic [15:0] x_planet,
  output logic [15:0] y_planet,
  output logic        frame_tick,
  output logic        hit,
  output logic [1:0]  lives,
  output logic        game_over
);

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int HIT_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;

  localparam logic [DIV_W-1:0] c_div_last   = DIV_W'(FRAME_DIV - 1);
  localparam logic [HIT_W-1:0] c_hit_load   = HIT_W'(HIT_FRAMES - 1);
  localparam logic [1:0]       c_lives_init = 2'(LIVES_INIT);
  localparam logic [15:0]      c_x_max      = 16'(X_MAX);
  localparam logic [15:0]      c_y_max      = 16'(Y_MAX);
  localparam logic [15:0]      c_ship_step  = 16'(SHIP_STEP);
  localparam logic [15:0]      c_plan_step  = 16'(PLANET_STEP);
  localparam logic [15:0]      c_ship_x0    = 16'(SHIP_X0);
  localparam logic [15:0]      c_ship_y0    = 16'(SHIP_Y0);
  localparam logic [15:0]      c_planet_x0  = 16'(PLANET_X0);
  localparam logic [15:0]      c_planet_y0  = 16'(PLANET_Y0);

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HIT  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [1:0]       lives_q, lives_d;
  logic [15:0]      x_ship_q, x_ship_d, y_ship_q, y_ship_d;
  logic [15:0]      x_planet_q, x_planet_d, y_planet_q, y_planet_d;
  logic [3:0]       btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d, btn_prev_q, btn_prev_d;

  logic             tick;
  logic             coll;
  logic [3:0]       btn_rise;
  logic signed [16:0] dx, dy, adx, ady;

  // One step toward inc or dec, saturating at 0 and at lim; inc and dec together cancel.
  function automatic logic [15:0] step_sat(input logic [15:0] pos, input logic inc,
                                           input logic dec, input logic [15:0] step,
                                           input logic [15:0] lim);
    logic [16:0] sum;
    sum      = {1'b0, pos} + {1'b0, step};
    step_sat = pos;
    if (inc && !dec) begin
      step_sat = (sum > {1'b0, lim}) ? lim : sum[15:0];
    end else if (dec && !inc) begin
      step_sat = (pos < step) ? 16'd0 : (pos - step);
    end
  endfunction

  assign tick     = (div_q == c_div_last);
  assign btn_rise = btn_s2_q & ~btn_prev_q;

  // Signed distance between the sprites; a hit when both axes are within 8 px.
  always_comb begin
    dx   = $signed({1'b0, x_planet_q}) - $signed({1'b0, x_ship_q});
    dy   = $signed({1'b0, y_planet_q}) - $signed({1'b0, y_ship_q});
    adx  = (dx < 0) ? -dx : dx;
    ady  = (dy < 0) ? -dy : dy;
    coll = (adx <= 17'sd8) && (ady <= 17'sd8);
  end

  // Next-state logic: synchronizers, frame divider and the PLAY/HIT/OVER game FSM.
  always_comb begin
    btn_s1_d   = {btn_down, btn_up, btn_right, btn_left};
    btn_s2_d   = btn_s1_q;
    btn_prev_d = btn_s2_q;
    div_d      = tick ? '0 : (div_q + DIV_W'(1));
    state_d    = state_q;
    hit_cnt_d  = hit_cnt_q;
    lives_d    = lives_q;
    x_ship_d   = x_ship_q;
    y_ship_d   = y_ship_q;
    x_planet_d = x_planet_q;
    y_planet_d = y_planet_q;

    case (state_q)
      ST_PLAY: begin
        if (tick) begin
          if (coll) begin
            // Collision wins over movement; the ship and planet stay put.
            if (lives_q <= 2'd1) begin
              lives_d = 2'd0;
              state_d = ST_OVER;
            end else begin
              lives_d   = lives_q - 2'd1;
              hit_cnt_d = c_hit_load;
              state_d   = ST_HIT;
            end
          end else begin
            x_ship_d   = step_sat(x_ship_q, btn_s2_q[1], btn_s2_q[0], c_ship_step, c_x_max);
            y_ship_d   = step_sat(y_ship_q, btn_s2_q[3], btn_s2_q[2], c_ship_step, c_y_max);
            x_planet_d = step_sat(x_planet_q, !h_reverse, h_reverse, c_plan_step, c_x_max);
            y_planet_d = step_sat(y_planet_q, !v_reverse, v_reverse, c_plan_step, c_y_max);
          end
        end
      end
      ST_HIT: begin
        if (tick) begin
          if (hit_cnt_q == '0) begin
            x_ship_d   = c_ship_x0;
            y_ship_d   = c_ship_y0;
            x_planet_d = c_planet_x0;
            y_planet_d = c_planet_y0;
            state_d    = ST_PLAY;
          end else begin
            hit_cnt_d = hit_cnt_q - HIT_W'(1);
          end
        end
      end
      ST_OVER: begin
        // Restart on any fresh press, independent of the frame divider.
        if (btn_rise != 4'd0) begin
          lives_d    = c_lives_init;
          x_ship_d   = c_ship_x0;
          y_ship_d   = c_ship_y0;
          x_planet_d = c_planet_x0;
          y_planet_d = c_planet_y0;
          state_d    = ST_PLAY;
        end
      end
      default: state_d = ST_PLAY;
    endcase
  end

  // State register with asynchronous reset to the spawn configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_PLAY;
      div_q      <= '0;
      hit_cnt_q  <= '0;
      lives_q    <= c_lives_init;
      x_ship_q   <= c_ship_x0;
      y_ship_q   <= c_ship_y0;
      x_planet_q <= c_planet_x0;
      y_planet_q <= c_planet_y0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      hit_cnt_q  <= hit_cnt_d;
      lives_q    <= lives_d;
      x_ship_q   <= x_ship_d;
      y_ship_q   <= y_ship_d;
      x_planet_q <= x_planet_d;
      y_planet_q <= y_planet_d;
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      btn_prev_q <= btn_prev_d;
    end
  end

  assign x_ship     = x_ship_q;
  assign y_ship     = y_ship_q;
  assign x_planet   = x_planet_q;
  assign y_planet   = y_planet_q;
  assign frame_tick = tick;
  assign hit        = (state_q == ST_HIT);
  assign game_over  = (state_q == ST_OVER);
  assign lives      = lives_q;

endmodule
`default_nettype wire
